// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver running entirely in the CLOCK_50
// domain. The raw PS/2 clock and data lines are synchronised, and the clock is
// glitch filtered. Frames are reassembled on filtered falling edges, then
// parity and stop bit are checked. A validated byte is presented with a
// one-cycle scanValid strobe. A rejected frame (bad parity, bad stop bit or
// stalled clock) gives a one-cycle frameError strobe instead.
module ps2_rx #(
    parameter int FILTER_LEN     = 8,      // cycles a new clock level must persist (2..200)
    parameter int TIMEOUT_CYCLES = 50000   // stall limit between falls inside a frame
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] scanCode,
    output logic       scanValid,
    output logic       frameError,
    output logic       busy
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int         TCW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] FILT_TERM = 8'(FILTER_LEN);
    localparam logic [7:0] FILT_ONE  = 8'd1;
    localparam logic [TCW-1:0] TO_TERM  = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [TCW-1:0] TCNT_ONE = TCW'(1);
    localparam logic [TCW-1:0] TCNT_ZERO = TCW'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Odd parity: the data byte together with its parity bit must hold an
    // odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // ------------------------------------------------------------------
    // Synchroniser and glitch filter state
    // ------------------------------------------------------------------
    logic       clk_s1_q, clk_s2_q;
    logic       dat_s1_q, dat_s2_q;
    logic       filt_clk_q, filt_clk_d;
    logic       filt_prev_q;
    logic [7:0] filt_cnt_q, filt_cnt_d;
    logic       fall_s;

    // ------------------------------------------------------------------
    // Frame FSM state
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     sr_q, sr_d;
    logic           par_q, par_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic           timeout_s;

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [7:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;

    // Two-flop synchronisers for both PS/2 lines; the bus idles high.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= PS2_CLK;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= PS2_DAT;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: count consecutive cycles where the synced clock disagrees
    // with the filtered clock, and adopt the new level once the count has
    // reached FILTER_LEN.
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = filt_cnt_q;
        if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FILT_TERM) begin
                filt_clk_d = clk_s2_q;
                filt_cnt_d = 8'd0;
            end else begin
                filt_cnt_d = filt_cnt_q + FILT_ONE;
            end
        end else begin
            filt_cnt_d = 8'd0;
        end
    end

    // Filter state registers plus the one-cycle history used for edge detection.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= 8'd0;
        end else begin
            filt_clk_q  <= filt_clk_d;
            filt_prev_q <= filt_clk_q;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    // A filtered falling edge is the only event that samples data.
    assign fall_s = filt_prev_q & ~filt_clk_q;

    // A stalled frame times out. A fall that lands on the terminal count takes
    // priority over the timeout.
    assign timeout_s = (state_q != ST_IDLE) && !fall_s && (tcnt_q == TO_TERM);

    // Frame FSM next state, datapath and strobe generation.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        par_d     = par_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        if (timeout_s) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fall_s && !dat_s2_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                        sr_d      = 8'h00;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (fall_s) begin
                        sr_d = {dat_s2_q, sr_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            state_d   = ST_PARITY;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    if (fall_s) begin
                        par_d   = dat_s2_q;
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_PARITY;
                    end
                end
                ST_STOP: begin
                    if (fall_s) begin
                        if (dat_s2_q && odd_parity_ok(sr_q, par_q)) begin
                            code_d  = sr_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Inter-edge timer: cleared by every fall and whenever the FSM is idle.
    always_comb begin
        if ((state_q == ST_IDLE) || fall_s) begin
            tcnt_d = TCNT_ZERO;
        end else begin
            tcnt_d = tcnt_q + TCNT_ONE;
        end
    end

    // Busy follows the next state so it is registered alongside the FSM.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
    end

    // FSM, datapath and output registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            sr_q      <= 8'h00;
            par_q     <= 1'b0;
            tcnt_q    <= TCNT_ZERO;
            code_q    <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            par_q     <= par_d;
            tcnt_q    <= tcnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign scanCode   = code_q;
    assign scanValid  = valid_q;
    assign frameError = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed frames into ps2_rx with hand-computed expectations.
// A PS/2 half-period of 250 system cycles keeps the run short while staying
// far above the filter length and far below the timeout.
module tb_ps2_rx;

    localparam int FLEN = 8;
    localparam int TOUT = 5000;
    localparam int HALF = 250;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic [7:0] scanCode;
    logic       scanValid;
    logic       frameError;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int last_valid_cyc = 0;
    int stop_cyc = 0;
    logic busy_mid = 1'b0;
    logic busy_seen = 1'b0;
    logic prev_pulse = 1'b0;
    int v0, e0;

    ps2_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOUT)) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .scanCode  (scanCode),
        .scanValid (scanValid),
        .frameError(frameError),
        .busy      (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Pulse monitor, sampled on the inactive clock edge.
    always @(negedge CLOCK_50) begin
        if (scanValid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
        if (frameError) err_cnt <= err_cnt + 1;
        if (busy) busy_seen <= 1'b1;
        if (scanValid | frameError) begin
            check("pulse_exclusive", {31'd0, scanValid & frameError}, 32'd0);
            check("pulse_single_cycle", {31'd0, prev_pulse}, 32'd0);
        end
        prev_pulse <= scanValid | frameError;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Sends the first n bits of bits[], LSB (start bit) first.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = bits[i];
            wait_cyc(HALF / 2);
            PS2_CLK = 1'b0;
            if (i == 10) stop_cyc = cyc;
            wait_cyc(HALF / 2);
            if (i == 5) busy_mid = busy;
            wait_cyc(HALF / 2);
            PS2_CLK = 1'b1;
            wait_cyc(HALF / 2);
        end
        PS2_DAT = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bits({s, p, d, 1'b0}, 11);
    endtask

    task automatic snap();
        v0 = valid_cnt;
        e0 = err_cnt;
    endtask

    initial begin
        wait_cyc(5);
        check("rst_code", {24'd0, scanCode}, 32'h00);
        check("rst_valid", {31'd0, scanValid}, 32'd0);
        check("rst_err", {31'd0, frameError}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        wait_cyc(20);

        // 0x1C has three ones -> parity 0.
        snap();
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_cyc(20);
        check("f1c_code", {24'd0, scanCode}, 32'h1C);
        check("f1c_valid_cnt", valid_cnt - v0, 32'd1);
        check("f1c_err_cnt", err_cnt - e0, 32'd0);
        // Stop fall driven on a negedge is captured on the next posedge,
        // then FLEN+3 cycles to the visible strobe.
        check("f1c_latency", last_valid_cyc - stop_cyc, FLEN + 3 + 1);
        check("f1c_busy_mid", {31'd0, busy_mid}, 32'd1);
        check("f1c_busy_after", {31'd0, busy}, 32'd0);

        // Back-to-back 0xF0 (parity 1) then 0x1C.
        snap();
        send_frame(8'hF0, 1'b1, 1'b1);
        check("b2b_code_f0", {24'd0, scanCode}, 32'hF0);
        send_frame(8'h1C, 1'b0, 1'b1);
        wait_cyc(20);
        check("b2b_code_1c", {24'd0, scanCode}, 32'h1C);
        check("b2b_valid_cnt", valid_cnt - v0, 32'd2);
        check("b2b_err_cnt", err_cnt - e0, 32'd0);

        // 0x12 needs parity 1; send 0.
        snap();
        send_frame(8'h12, 1'b0, 1'b1);
        wait_cyc(20);
        check("par_err_cnt", err_cnt - e0, 32'd1);
        check("par_valid_cnt", valid_cnt - v0, 32'd0);
        check("par_code_held", {24'd0, scanCode}, 32'h1C);

        // 0x59 with correct parity but stop bit 0.
        snap();
        send_frame(8'h59, 1'b1, 1'b0);
        wait_cyc(20);
        check("stop_err_cnt", err_cnt - e0, 32'd1);
        check("stop_valid_cnt", valid_cnt - v0, 32'd0);
        check("stop_code_held", {24'd0, scanCode}, 32'h1C);

        // Start bit plus 5 data bits, then the clock stops.
        snap();
        send_bits({1'b1, 1'b1, 8'h59, 1'b0}, 6);
        check("to_busy_during", {31'd0, busy}, 32'd1);
        wait_cyc(TOUT + 10);
        check("to_err_cnt", err_cnt - e0, 32'd1);
        check("to_valid_cnt", valid_cnt - v0, 32'd0);
        check("to_busy_after", {31'd0, busy}, 32'd0);
        snap();
        send_frame(8'h59, 1'b1, 1'b1);
        wait_cyc(20);
        check("to_next_code", {24'd0, scanCode}, 32'h59);
        check("to_next_valid", valid_cnt - v0, 32'd1);
        check("to_next_err", err_cnt - e0, 32'd0);

        // Short low glitch on the clock while idle.
        snap();
        busy_seen = 1'b0;
        PS2_CLK = 1'b0;
        wait_cyc(3);
        PS2_CLK = 1'b1;
        wait_cyc(50);
        check("glitch_busy", {31'd0, busy_seen}, 32'd0);
        check("glitch_valid", valid_cnt - v0, 32'd0);
        check("glitch_err", err_cnt - e0, 32'd0);

        // Reset in the middle of a frame, then a good 0x12.
        snap();
        send_bits({1'b1, 1'b1, 8'hA5, 1'b0}, 5);
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(20);
        check("rstmid_code", {24'd0, scanCode}, 32'h00);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h12, 1'b1, 1'b1);
        wait_cyc(20);
        check("rstmid_next_code", {24'd0, scanCode}, 32'h12);
        check("rstmid_valid", valid_cnt - v0, 32'd1);
        check("rstmid_err", err_cnt - e0, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
